// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// reset_seq_pkg: state codes and default parameters shared by reset_sequencer
// Revision 1.0
// =============================================================================
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_RUN       = 3'd4,
    ST_ERROR     = 3'd5
  } seq_state_e;

  localparam int DEF_N_DOMAINS   = 4;
  localparam int DEF_MIN_ASSERT  = 8;
  localparam int DEF_STAGE_DELAY = 4;
  localparam int DEF_ACK_TIMEOUT = 32;
  localparam int DEF_CNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// =============================================================================
// reset_sequencer_if: per-domain reset / acknowledge bundle
// Revision 1.0
// =============================================================================
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS = DEF_N_DOMAINS
);
  logic [N_DOMAINS-1:0] DOMAIN_RESET_N;
  logic [N_DOMAINS-1:0] DOMAIN_ACK;

  modport master (output DOMAIN_RESET_N, input DOMAIN_ACK);
  modport slave  (input DOMAIN_RESET_N, output DOMAIN_ACK);
endinterface
`default_nettype wire

// File: rtl/reset_sequencer_sync_2ff.sv
`default_nettype none
// =============================================================================
// sync_2ff: two-flop synchroniser, clears to 0 under reset
// Revision 1.0
// =============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             INTERNAL_RST,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// =============================================================================
// reset_sequencer: staged, acknowledged release of per-domain resets
// Revision 1.0
// =============================================================================
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = DEF_N_DOMAINS,
  parameter int MIN_ASSERT  = DEF_MIN_ASSERT,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                     CLK,
  input  logic                     INTERNAL_RST,
  input  logic                     PLL_LOCK,
  input  logic                     INIT_DONE,
  input  logic                     SW_RST_REQ,
  reset_sequencer_if.master        dom,
  output logic                     SEQ_DONE,
  output logic                     SEQ_ERROR,
  output logic [2:0]               SEQ_STATE
);
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_DOMAINS - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic                 pll_lock_s;
  logic                 init_done_s;
  logic [N_DOMAINS-1:0] ack_s;

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                 lock_lost;
  logic                 abort;

  sync_2ff #(.WIDTH(1)) u_sync_lock (
    .CLK(CLK), .INTERNAL_RST(INTERNAL_RST), .d_i(PLL_LOCK), .q_o(pll_lock_s)
  );
  sync_2ff #(.WIDTH(1)) u_sync_init (
    .CLK(CLK), .INTERNAL_RST(INTERNAL_RST), .d_i(INIT_DONE), .q_o(init_done_s)
  );
  sync_2ff #(.WIDTH(N_DOMAINS)) u_sync_ack (
    .CLK(CLK), .INTERNAL_RST(INTERNAL_RST), .d_i(dom.DOMAIN_ACK), .q_o(ack_s)
  );

  // Lock loss only matters once release has begun; ERROR waits for software.
  assign lock_lost = !pll_lock_s &&
                     (state_q inside {ST_RELEASE, ST_WAIT_ACK, ST_RUN});
  assign abort     = lock_lost || (SW_RST_REQ && (state_q != ST_ASSERT));

  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;

    if (abort) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_n_d = '0;
          idx_d   = '0;
          // A held software request keeps restarting the minimum hold.
          if (SW_RST_REQ) begin
            cnt_d = '0;
          end else if (cnt_q == ASSERT_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (pll_lock_s && init_done_s) begin
            state_d = ST_RELEASE;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            rst_n_d[idx_q] = 1'b1;
            state_d        = ST_WAIT_ACK;
            cnt_d          = '0;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_s[idx_q]) begin
            state_d = (idx_q == LAST_IDX) ? ST_RUN : ST_RELEASE;
            idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == ACK_LAST) begin
            state_d = ST_ERROR;
            rst_n_d = '0;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
        end
        ST_ERROR: begin
          rst_n_d = '0;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
        end
      endcase
    end
  end

  assign dom.DOMAIN_RESET_N = rst_n_q;
  assign SEQ_DONE           = (state_q == ST_RUN);
  assign SEQ_ERROR          = (state_q == ST_ERROR);
  assign SEQ_STATE          = state_q;
endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// =============================================================================
// tb_reset_sequencer: table, directed and randomised checks of reset_sequencer
// Revision 1.0
// =============================================================================
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int N     = 4;
  localparam int MIN_A = 8;
  localparam int STG   = 4;
  localparam int TMO   = 32;
  localparam int WIN   = 220;

  typedef int dom_arr_t [N];
  typedef struct {
    int init_at;
    int d0, d1, d2, d3;
    int r0, r1, r2, r3;
    int done_at;
    int err_at;
  } vec_t;

  logic         CLK          = 1'b0;
  logic         INTERNAL_RST = 1'b0;
  logic         PLL_LOCK     = 1'b1;
  logic         INIT_DONE    = 1'b1;
  logic         SW_RST_REQ   = 1'b0;
  logic [N-1:0] ack_q        = '0;
  logic [N-1:0] ack_mask     = '0;
  logic         SEQ_DONE;
  logic         SEQ_ERROR;
  logic [2:0]   SEQ_STATE;
  int           cyc    = 0;
  int           n_chk  = 0;
  int           n_fail = 0;

  reset_sequencer_if #(.N_DOMAINS(N)) dom_if ();
  assign dom_if.DOMAIN_ACK = (dom_if.DOMAIN_RESET_N & ack_mask) | ack_q;

  reset_sequencer #(
    .N_DOMAINS(N), .MIN_ASSERT(MIN_A), .STAGE_DELAY(STG), .ACK_TIMEOUT(TMO), .CNT_W(8)
  ) dut (
    .CLK(CLK), .INTERNAL_RST(INTERNAL_RST), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
    .SW_RST_REQ(SW_RST_REQ), .dom(dom_if.master), .SEQ_DONE(SEQ_DONE),
    .SEQ_ERROR(SEQ_ERROR), .SEQ_STATE(SEQ_STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input integer act, input integer exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  // Short asynchronous reset pulse between edges; edge numbering restarts at 1.
  task automatic pulse_reset();
    INTERNAL_RST = 1'b0;
    #1;
    INTERNAL_RST = 1'b1;
    cyc = 0;
  endtask

  // Timeline model: stage i counts STG cycles after its start, each input
  // change reaches the FSM three edges after it is driven, and an ack that
  // cannot arrive before TMO cycles of waiting ends the run in ERROR.
  function automatic void model(input int init_at, input dom_arr_t dly,
                                output dom_arr_t rise, output int done_at,
                                output int err_at);
    int start;
    start   = (init_at + 3 > MIN_A + 1) ? init_at + 3 : MIN_A + 1;
    done_at = -1;
    err_at  = -1;
    for (int i = 0; i < N; i++) rise[i] = -1;
    for (int i = 0; i < N; i++) begin
      rise[i] = start + STG;
      if (dly[i] + 3 >= TMO) begin
        err_at = rise[i] + TMO;
        return;
      end
      start = rise[i] + dly[i] + 3;
      if (i == N - 1) done_at = start;
    end
  endfunction

  task automatic run_trial(input int init_at, input dom_arr_t dly,
                           output dom_arr_t rise, output int done_at,
                           output int err_at, output int dirty);
    PLL_LOCK   = 1'b1;
    SW_RST_REQ = 1'b0;
    ack_mask   = '0;
    ack_q      = '0;
    INIT_DONE  = (init_at <= 0);
    pulse_reset();
    for (int i = 0; i < N; i++) rise[i] = -1;
    done_at = -1;
    err_at  = -1;
    dirty   = 0;
    repeat (WIN) begin
      tick();
      for (int i = 0; i < N; i++)
        if (rise[i] < 0 && dom_if.DOMAIN_RESET_N[i] === 1'b1) rise[i] = cyc;
      if (done_at < 0 && SEQ_DONE === 1'b1) done_at = cyc;
      if (err_at < 0 && SEQ_ERROR === 1'b1) err_at = cyc;
      if (SEQ_ERROR === 1'b1 && dom_if.DOMAIN_RESET_N !== '0) dirty++;
      if (cyc == init_at) INIT_DONE = 1'b1;
      for (int i = 0; i < N; i++)
        if (rise[i] >= 0 && cyc >= rise[i] + dly[i]) ack_q[i] = 1'b1;
    end
  endtask

  task automatic check_trial(input string tag, input dom_arr_t er, input int ed,
                             input int ee, input dom_arr_t ar, input int ad,
                             input int ae, input int dirty);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s rise[%0d]", tag, i), ar[i], er[i]);
    chk({tag, " done_cycle"}, ad, ed);
    chk({tag, " error_cycle"}, ae, ee);
    chk({tag, " resets_in_error"}, dirty, 0);
  endtask

  vec_t vecs [6];

  initial begin
    dom_arr_t d, er, ar;
    int       ed, ee, ad, ae, dirty, ia, stray;

    vecs[0] = '{0,   0, 0, 0, 0,    13,  20,  27,  34,  37, -1};
    vecs[1] = '{0,   0, 0, 40, 0,   13,  20,  27,  -1,  -1, 59};
    vecs[2] = '{100, 0, 0, 0, 0,    107, 114, 121, 128, 131, -1};
    vecs[3] = '{0,   28, 0, 0, 0,   13,  48,  55,  62,  65, -1};
    vecs[4] = '{0,   0, 0, 0, 30,   13,  20,  27,  34,  -1, 66};
    vecs[5] = '{0,   5, 1, 2, 3,    13,  25,  33,  42,  48, -1};

    // ---- Reset values, lock loss, coincident abort, async reset ----
    ack_mask = '1;
    repeat (3) tick();
    chk("reset SEQ_STATE", SEQ_STATE, 0);
    chk("reset DOMAIN_RESET_N", dom_if.DOMAIN_RESET_N, 0);
    chk("reset SEQ_DONE", SEQ_DONE, 0);
    chk("reset SEQ_ERROR", SEQ_ERROR, 0);
    INTERNAL_RST = 1'b1;
    cyc = 0;

    tick_to(17);
    chk("stage1 state", SEQ_STATE, 2);
    chk("stage1 resets", dom_if.DOMAIN_RESET_N, 4'b0001);
    PLL_LOCK = 1'b0;
    tick_to(19);
    chk("lockloss latency hold", dom_if.DOMAIN_RESET_N, 4'b0001);
    tick_to(20);
    chk("lockloss resets", dom_if.DOMAIN_RESET_N, 0);
    chk("lockloss state", SEQ_STATE, 0);
    tick_to(40);
    chk("lockloss waits", SEQ_STATE, 1);
    PLL_LOCK = 1'b1;
    tick_to(46);
    chk("relock before d0", dom_if.DOMAIN_RESET_N, 0);
    tick_to(47);
    chk("relock d0 release", dom_if.DOMAIN_RESET_N, 4'b0001);
    tick_to(70);
    chk("relock done early", SEQ_DONE, 0);
    tick_to(71);
    chk("relock done", SEQ_DONE, 1);
    chk("relock run state", SEQ_STATE, 4);
    chk("relock all released", dom_if.DOMAIN_RESET_N, 4'b1111);

    tick_to(75);
    PLL_LOCK   = 1'b0;
    SW_RST_REQ = 1'b1;
    tick_to(76);
    chk("coincident state", SEQ_STATE, 0);
    chk("coincident done", SEQ_DONE, 0);
    chk("coincident resets", dom_if.DOMAIN_RESET_N, 0);
    SW_RST_REQ = 1'b0;
    PLL_LOCK   = 1'b1;
    stray = 0;
    while (cyc < 83) begin
      tick();
      if (SEQ_STATE !== 3'd0) stray++;
    end
    chk("coincident hold", stray, 0);
    tick_to(84);
    chk("coincident min_assert", SEQ_STATE, 1);
    tick_to(89);
    chk("coincident d0", dom_if.DOMAIN_RESET_N, 4'b0001);
    tick_to(90);
    chk("wait_ack state", SEQ_STATE, 3);
    INTERNAL_RST = 1'b0;
    #1;
    chk("async SEQ_STATE", SEQ_STATE, 0);
    chk("async DOMAIN_RESET_N", dom_if.DOMAIN_RESET_N, 0);
    chk("async SEQ_DONE", SEQ_DONE, 0);
    chk("async SEQ_ERROR", SEQ_ERROR, 0);
    INTERNAL_RST = 1'b1;
    cyc = 0;
    tick_to(12);
    chk("restart before d0", dom_if.DOMAIN_RESET_N, 0);
    tick_to(13);
    chk("restart d0", dom_if.DOMAIN_RESET_N, 4'b0001);
    tick_to(36);
    chk("restart done early", SEQ_DONE, 0);
    tick_to(37);
    chk("restart done", SEQ_DONE, 1);

    // ---- Timeout, software recovery, held software request ----
    tick_to(40);
    ack_mask   = 4'b1011;
    SW_RST_REQ = 1'b1;
    tick_to(41);
    chk("sw from run", SEQ_STATE, 0);
    SW_RST_REQ = 1'b0;
    tick_to(99);
    chk("timeout pending", SEQ_STATE, 3);
    tick_to(100);
    chk("timeout state", SEQ_STATE, 5);
    chk("timeout SEQ_ERROR", SEQ_ERROR, 1);
    chk("timeout resets", dom_if.DOMAIN_RESET_N, 0);
    tick_to(110);
    chk("error holds", SEQ_STATE, 5);
    SW_RST_REQ = 1'b1;
    tick_to(111);
    chk("error exit state", SEQ_STATE, 0);
    chk("error exit SEQ_ERROR", SEQ_ERROR, 0);
    ack_mask = '1;
    tick_to(122);
    SW_RST_REQ = 1'b0;
    tick_to(129);
    chk("sw hold restart", SEQ_STATE, 0);
    tick_to(130);
    chk("sw hold wait_lock", SEQ_STATE, 1);
    tick_to(159);
    chk("recovered done", SEQ_DONE, 1);
    chk("recovered state", SEQ_STATE, 4);

    // ---- Table vectors ----
    for (int v = 0; v < 6; v++) begin
      d  = '{vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3};
      er = '{vecs[v].r0, vecs[v].r1, vecs[v].r2, vecs[v].r3};
      run_trial(vecs[v].init_at, d, ar, ad, ae, dirty);
      check_trial($sformatf("vec%0d", v), er, vecs[v].done_at, vecs[v].err_at,
                  ar, ad, ae, dirty);
    end

    // ---- Randomised trials against the timeline model ----
    for (int t = 0; t < 16; t++) begin
      ia = int'($urandom_range(0, 30));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) d[i] = int'($urandom_range(30, 45));
        else                           d[i] = int'($urandom_range(0, 28));
      end
      model(ia, d, er, ed, ee);
      run_trial(ia, d, ar, ad, ae, dirty);
      check_trial($sformatf("rand%0d", t), er, ed, ee, ar, ad, ae, dirty);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences the release of up to N fabric reset domains in a fixed order after the chip-level reset network has settled. It sits directly downstream of the synchronised fabric reset generator: that generator produces INTERNAL_RST, and this block turns it into per-domain resets. Release is staged, with one domain at a time, a programmable gap between stages, and an acknowledge from each domain before the next is released. The block re-asserts every domain on PLL lock loss or on a software reset request, and flags domains that never acknowledge.

## Interface
Parameters:
- N_DOMAINS, default 4: number of reset domains, legal range 1..8.
- MIN_ASSERT, default 8: minimum number of cycles all domains are held in reset, legal range ≥2.
- STAGE_DELAY, default 4: cycles from entering a stage to releasing that stage's domain, legal range ≥1.
- ACK_TIMEOUT, default 32: cycles allowed for a domain to acknowledge after release.
- CNT_W, default 8: counter width; must satisfy 2^CNT_W > max(MIN_ASSERT, STAGE_DELAY, ACK_TIMEOUT).

Ports, clock and reset first:
- CLK, in, 1: block clock.
- INTERNAL_RST, in, 1: reset, asynchronous, active-low. Clock is CLK.
- PLL_LOCK, in, 1: PLL lock. Asynchronous; synchronised internally.
- INIT_DONE, in, 1: device initialisation complete. Asynchronous; synchronised internally.
- SW_RST_REQ, in, 1: software reset request. Synchronous to CLK, level-sampled.
- DOMAIN_ACK, in, N_DOMAINS: per-domain "out of reset" acknowledge. Asynchronous; synchronised internally.
- DOMAIN_RESET_N, out, N_DOMAINS: per-domain reset, active-low, registered.
- SEQ_DONE, out, 1: high while all domains are released (RUN state).
- SEQ_ERROR, out, 1: high while in ERROR.
- SEQ_STATE, out, 3: current FSM state code, for debug.

## Operation
- Reset value of all outputs while INTERNAL_RST is low: DOMAIN_RESET_N=0 for every domain, SEQ_DONE=0, SEQ_ERROR=0, SEQ_STATE=0. FSM goes to ASSERT, counter is cleared, stage index is 0.
- States and SEQ_STATE codes: ASSERT=0, WAIT_LOCK=1, RELEASE=2, WAIT_ACK=3, RUN=4, ERROR=5. Codes 6 and 7 are unreachable and recover to ASSERT.
- ASSERT: all DOMAIN_RESET_N are 0. Count MIN_ASSERT cycles, then go to WAIT_LOCK.
- WAIT_LOCK: when synchronised PLL_LOCK and INIT_DONE are both 1, set idx=0 and go to RELEASE.
- RELEASE: count STAGE_DELAY cycles. On the last count, set DOMAIN_RESET_N[idx]=1 and go to WAIT_ACK.
- WAIT_ACK: when synchronised DOMAIN_ACK[idx]=1, either increment idx and go to RELEASE, or go to RUN if idx==N_DOMAINS-1. If ACK_TIMEOUT cycles elapse without an acknowledge, go to ERROR.
- RUN: SEQ_DONE=1. All domains stay released.
- ERROR: all DOMAIN_RESET_N are 0 and SEQ_ERROR=1. The only exit is SW_RST_REQ=1, which goes to ASSERT.
- Priority of events, evaluated each cycle:
  1. Synchronised PLL_LOCK=0 in any state other than ASSERT, WAIT_LOCK or ERROR goes to ASSERT.
  2. SW_RST_REQ=1 in any state other than ASSERT goes to ASSERT.
  3. Otherwise the normal transition applies.
  A simultaneous lock loss and software request resolves to ASSERT, with the same outcome either way.
- Any entry to ASSERT drives every DOMAIN_RESET_N to 0 in the same cycle as the state update, clears SEQ_DONE, reloads the counter and sets idx=0.
- Holding SW_RST_REQ high keeps the FSM in ASSERT. The MIN_ASSERT count restarts from its deassertion.
- Already-released domains stay released through later stages. An acknowledge that drops after release is ignored.
- Counters saturate. The counter is reloaded on every state entry.

## Timing
- Every input synchroniser has 2-cycle latency.
- PLL_LOCK and INIT_DONE both high at edge k, in WAIT_LOCK: RELEASE is entered at k+3, and DOMAIN_RESET_N[0] rises at k+3+STAGE_DELAY.
- An acknowledge sampled high at edge a leads to the next stage's RELEASE entry at a+3.
- Timeout: ERROR is entered exactly ACK_TIMEOUT cycles after WAIT_ACK entry when no acknowledge arrives.
- Release of all domains happens at least MIN_ASSERT+1 cycles after INTERNAL_RST rises.
- Synchronised lock loss is observed 2 cycles after PLL_LOCK falls. Resets assert on the following edge.
- SEQ_DONE rises on the same edge as the transition into RUN.

## Structure
- Shared package reset_seq_pkg holds:
  - the state enum and its codes;
  - the default parameter constants.
- One sub-module, sync_2ff: a 2-flop synchroniser with a width parameter and reset value 0, instantiated for PLL_LOCK, INIT_DONE and DOMAIN_ACK.
- The top level contains the FSM, one shared counter and the idx register.

## Test plan
All scenarios use N_DOMAINS=4, MIN_ASSERT=8, STAGE_DELAY=4, ACK_TIMEOUT=32.
1. Nominal sequence: INTERNAL_RST released; PLL_LOCK and INIT_DONE high from the start; each acknowledge tied to its reset output -> domains 0..3 released in order, stages spaced 4+3 cycles apart, SEQ_DONE=1, SEQ_STATE=4.
2. Acknowledge timeout: DOMAIN_ACK[2] held at 0 -> ERROR after 32 cycles in WAIT_ACK. SEQ_ERROR=1 and all resets are 0. A SW_RST_REQ pulse -> ASSERT, then the full sequence repeats.
3. Lock loss mid-sequence: PLL_LOCK drops during stage 1 RELEASE -> all resets are 0 within 3 cycles. The FSM waits in WAIT_LOCK until lock returns, then restarts from domain 0.
4. Lock loss in RUN, coincident with SW_RST_REQ -> a single entry to ASSERT, SEQ_DONE=0, and the MIN_ASSERT hold is honoured.
5. Async reset mid-operation: INTERNAL_RST is pulsed low for 1 ns during WAIT_ACK -> outputs go immediately to their reset values, and the sequence restarts cleanly.
6. Late INIT_DONE: INIT_DONE arrives 100 cycles after lock -> the FSM stays in WAIT_LOCK, and DOMAIN_RESET_N[0] rises exactly 3+4 cycles after INIT_DONE is sampled.
